// File: rtl/rom_prgmr_pkg.sv
// Shared constants for the multi-channel ROM programmer: register indices,
// CTRL/STATUS bit positions and the access FSM state encoding.
// No logic; imported by rom_prgmr_mc and rom_prgmr_chan_mux.
package rom_prgmr_pkg;

  // Avalon register indices
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_PTR    = 3'd1;
  localparam logic [2:0] REG_DATA   = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;
  localparam logic [2:0] REG_CSUM   = 3'd4;

  // CTRL fields
  localparam int CTRL_CH_LSB   = 0;
  localparam int CTRL_CH_W     = 3;
  localparam int CTRL_HOLD_BIT = 8;

  // STATUS fields
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_ERR_BIT  = 1;
  localparam int STAT_OVF_BIT  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/rom_prgmr_chan_mux.sv
// Channel decode: turns CH plus the write/read strobe into one-hot per-channel
// enables and selects that channel's slice of the ROM read data.
// Latency: combinational. Backpressure: none.
// Ports: ch (channel select), wr_en/rd_en (strobes), from_rom (all channels),
//        read_rom/write_rom (one-hot enables), rd_data (selected slice).
module rom_prgmr_chan_mux
  import rom_prgmr_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 8
) (
  input  logic [CTRL_CH_W-1:0]     ch,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [NUM_CH*DATA_W-1:0] from_rom,
  output logic [NUM_CH-1:0]        read_rom,
  output logic [NUM_CH-1:0]        write_rom,
  output logic [DATA_W-1:0]        rd_data
);

  // An out-of-range channel matches no index: no strobe, zero data.
  always_comb begin
    read_rom  = '0;
    write_rom = '0;
    rd_data   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(ch) == c) begin
        read_rom[c]  = rd_en;
        write_rom[c] = wr_en;
        rd_data      = from_rom[c*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/rom_prgmr_mc.sv
// Avalon-MM slave that loads game images into NUM_CH ROM/RAM channels through
// an auto-incrementing pointer, holding the NES core off the ROMs meanwhile.
// Latency: register accesses 0 wait; DATA write 2 waits; DATA read RD_LAT+1 waits.
// Backpressure: AVL_WAITREQUEST stalls the master for the whole DATA access.
// Ports: AVL_* slave bus; FROM_ROM per-channel read data; ROM_ADDR/TO_ROM shared
//        address/write data (held between strobes); READ_ROM/WRITE_ROM one-hot
//        strobes; NES_HOLD keeps the NES core off the ROMs.
// Option: define ROM_PRGMR_CHECKSUM_EN for the 16-bit write checksum at reg 4.
module rom_prgmr_mc
  import rom_prgmr_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [2:0]               AVL_ADDR,
  input  logic                     AVL_CS,
  input  logic                     AVL_READ,
  input  logic                     AVL_WRITE,
  input  logic [31:0]              AVL_WRITEDATA,
  output logic [31:0]              AVL_READDATA,
  output logic                     AVL_WAITREQUEST,
  input  logic [NUM_CH*DATA_W-1:0] FROM_ROM,
  output logic [ADDR_W-1:0]        ROM_ADDR,
  output logic [DATA_W-1:0]        TO_ROM,
  output logic [NUM_CH-1:0]        READ_ROM,
  output logic [NUM_CH-1:0]        WRITE_ROM,
  output logic                     NES_HOLD
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  state_t                 state_q;
  logic [CTRL_CH_W-1:0]   ch_q;
  logic                   hold_q;
  logic [ADDR_W-1:0]      ptr_q;
  logic                   err_q;
  logic                   ovf_q;
  logic                   op_wr_q;
  logic                   wr_en_q;
  logic                   rd_en_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [ADDR_W-1:0]      rom_addr_q;
  logic [DATA_W-1:0]      to_rom_q;
  logic [DATA_W-1:0]      rdata_q;
  logic [DATA_W-1:0]      mux_rd_data;
`ifdef ROM_PRGMR_CHECKSUM_EN
  logic [15:0]            csum_q;
`endif

  // Simultaneous read and write is a write.
  logic acc, is_wr, is_rd, data_acc, data_ok, start;
  assign acc      = AVL_CS & (AVL_READ | AVL_WRITE);
  assign is_wr    = AVL_CS & AVL_WRITE;
  assign is_rd    = AVL_CS & AVL_READ & ~AVL_WRITE;
  assign data_acc = acc & (AVL_ADDR == REG_DATA);
  assign data_ok  = hold_q & (int'(ch_q) < NUM_CH);
  assign start    = (state_q == IDLE) & data_acc & data_ok;

  // The first wait cycle must be raised in the same cycle the access appears.
  assign AVL_WAITREQUEST = (state_q == IDLE) ? start : (state_q != DONE);

  assign ROM_ADDR = rom_addr_q;
  assign TO_ROM   = to_rom_q;
  assign NES_HOLD = hold_q;

  rom_prgmr_chan_mux #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W)
  ) u_chan_mux (
    .ch        (ch_q),
    .wr_en     (wr_en_q),
    .rd_en     (rd_en_q),
    .from_rom  (FROM_ROM),
    .read_rom  (READ_ROM),
    .write_rom (WRITE_ROM),
    .rd_data   (mux_rd_data)
  );

  always_comb begin
    AVL_READDATA = '0;
    if (is_rd) begin
      case (AVL_ADDR)
        REG_CTRL: begin
          AVL_READDATA[CTRL_CH_LSB +: CTRL_CH_W] = ch_q;
          AVL_READDATA[CTRL_HOLD_BIT]            = hold_q;
        end
        REG_PTR:  AVL_READDATA[ADDR_W-1:0] = ptr_q;
        REG_DATA: begin
          // Only the completing cycle of a read carries the captured data.
          if (state_q == DONE && !op_wr_q) AVL_READDATA[DATA_W-1:0] = rdata_q;
        end
        REG_STATUS: begin
          AVL_READDATA[STAT_BUSY_BIT] = (state_q != IDLE);
          AVL_READDATA[STAT_ERR_BIT]  = err_q;
          AVL_READDATA[STAT_OVF_BIT]  = ovf_q;
        end
`ifdef ROM_PRGMR_CHECKSUM_EN
        REG_CSUM: AVL_READDATA[15:0] = csum_q;
`endif
        default: AVL_READDATA = '0;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      hold_q     <= 1'b0;
      ptr_q      <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      op_wr_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      cnt_q      <= '0;
      rom_addr_q <= '0;
      to_rom_q   <= '0;
      rdata_q    <= '0;
`ifdef ROM_PRGMR_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      // Strobes are single-cycle pulses.
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (data_acc) begin
            if (data_ok) begin
              rom_addr_q <= ptr_q;
              op_wr_q    <= is_wr;
              if (is_wr) begin
                to_rom_q <= AVL_WRITEDATA[DATA_W-1:0];
                wr_en_q  <= 1'b1;
                state_q  <= WR;
              end else begin
                rd_en_q  <= 1'b1;
                cnt_q    <= CNT_W'(RD_LAT);
                state_q  <= RD_WAIT;
              end
            end else begin
              err_q <= 1'b1;
            end
          end else if (is_wr) begin
            case (AVL_ADDR)
              REG_CTRL: begin
                ch_q   <= AVL_WRITEDATA[CTRL_CH_LSB +: CTRL_CH_W];
                hold_q <= AVL_WRITEDATA[CTRL_HOLD_BIT];
              end
              REG_PTR: ptr_q <= AVL_WRITEDATA[ADDR_W-1:0];
              REG_STATUS: begin
                err_q <= err_q & ~AVL_WRITEDATA[STAT_ERR_BIT];
                ovf_q <= ovf_q & ~AVL_WRITEDATA[STAT_OVF_BIT];
              end
`ifdef ROM_PRGMR_CHECKSUM_EN
              REG_CSUM: csum_q <= '0;
`endif
              default: ;
            endcase
          end
        end
        WR: state_q <= DONE;
        RD_WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            rdata_q <= mux_rd_data;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          // Pointer (and checksum) only advance once the access has completed.
          ptr_q <= ptr_q + ADDR_W'(1);
          if (&ptr_q) ovf_q <= 1'b1;
`ifdef ROM_PRGMR_CHECKSUM_EN
          if (op_wr_q) csum_q <= csum_q + 16'(to_rom_q);
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Write-data bits outside the decoded fields are intentionally ignored.
  logic unused_wdata;
  assign unused_wdata = ^AVL_WRITEDATA;

endmodule

// File: tb/tb_rom_prgmr_mc.sv
// Directed bench for rom_prgmr_mc: register access, ROM write/read sequencing,
// error/overflow flags, pointer wrap, asynchronous reset mid-access, checksum.
module tb_rom_prgmr_mc;

  localparam int NUM_CH = 2;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;

  logic                     clk;
  logic                     rst;
  logic [2:0]               avl_addr;
  logic                     avl_cs;
  logic                     avl_read;
  logic                     avl_write;
  logic [31:0]              avl_writedata;
  logic [31:0]              avl_readdata;
  logic                     avl_waitrequest;
  logic [NUM_CH*DATA_W-1:0] from_rom;
  logic [ADDR_W-1:0]        rom_addr;
  logic [DATA_W-1:0]        to_rom;
  logic [NUM_CH-1:0]        read_rom;
  logic [NUM_CH-1:0]        write_rom;
  logic                     nes_hold;

  rom_prgmr_mc #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .CLK             (clk),
    .RESET           (rst),
    .AVL_ADDR        (avl_addr),
    .AVL_CS          (avl_cs),
    .AVL_READ        (avl_read),
    .AVL_WRITE       (avl_write),
    .AVL_WRITEDATA   (avl_writedata),
    .AVL_READDATA    (avl_readdata),
    .AVL_WAITREQUEST (avl_waitrequest),
    .FROM_ROM        (from_rom),
    .ROM_ADDR        (rom_addr),
    .TO_ROM          (to_rom),
    .READ_ROM        (read_rom),
    .WRITE_ROM       (write_rom),
    .NES_HOLD        (nes_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Strobe monitor: one entry per cycle a strobe is high.
  logic [NUM_CH-1:0] wr_stb_q[$];
  logic [ADDR_W-1:0] wr_adr_q[$];
  logic [DATA_W-1:0] wr_dat_q[$];
  logic [NUM_CH-1:0] rd_stb_q[$];
  logic [ADDR_W-1:0] rd_adr_q[$];

  always @(negedge clk) begin
    if (!rst && |write_rom) begin
      wr_stb_q.push_back(write_rom);
      wr_adr_q.push_back(rom_addr);
      wr_dat_q.push_back(to_rom);
    end
    if (!rst && |read_rom) begin
      rd_stb_q.push_back(read_rom);
      rd_adr_q.push_back(rom_addr);
    end
  end

  // One Avalon transfer; returns the readdata seen on the completing cycle
  // and the number of cycles spent with waitrequest high.
  task automatic bus_xfer(input logic wr, input logic [2:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    rd    = '0;
    @(posedge clk); #1;
    avl_cs = 1'b1; avl_addr = a; avl_write = wr; avl_read = ~wr; avl_writedata = wd;
    while (!done) begin
      @(negedge clk);
      if (!avl_waitrequest) begin
        rd   = avl_readdata;
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 50) begin
          check_val("bus_timeout", 32'(waits), 32'd0);
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    avl_cs = 1'b0; avl_write = 1'b0; avl_read = 1'b0;
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [31:0] wd);
    logic [31:0] rd;
    int w;
    bus_xfer(1'b1, a, wd, rd, w);
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [31:0] rd);
    int w;
    bus_xfer(1'b0, a, 32'd0, rd, w);
  endtask

  logic [31:0] rd;
  int          w;

  initial begin
    rst = 1'b1;
    avl_addr = '0; avl_cs = 1'b0; avl_read = 1'b0; avl_write = 1'b0;
    avl_writedata = '0; from_rom = '0;
    #23;
    check_val("rst_write_rom", 32'(write_rom), 32'h0);
    check_val("rst_read_rom",  32'(read_rom),  32'h0);
    check_val("rst_nes_hold",  32'(nes_hold),  32'h0);
    check_val("rst_rom_addr",  32'(rom_addr),  32'h0);
    check_val("rst_to_rom",    32'(to_rom),    32'h0);
    check_val("rst_waitreq",   32'(avl_waitrequest), 32'h0);
    @(negedge clk); rst = 1'b0;
    reg_rd(3'd0, rd); check_val("rst_ctrl", rd, 32'h0);
    reg_rd(3'd1, rd); check_val("rst_ptr", rd, 32'h0);
    reg_rd(3'd3, rd); check_val("rst_status", rd, 32'h0);

    // Two writes to channel 1
    reg_wr(3'd0, 32'h101);
    check_val("hold_set", 32'(nes_hold), 32'h1);
    reg_rd(3'd0, rd); check_val("ctrl_rb", rd, 32'h101);
    reg_wr(3'd1, 32'h0010);
    bus_xfer(1'b1, 3'd2, 32'hA5, rd, w); check_val("wr0_waits", 32'(w), 32'd2);
    bus_xfer(1'b1, 3'd2, 32'h3C, rd, w); check_val("wr1_waits", 32'(w), 32'd2);
    check_val("wr_pulses", 32'(wr_stb_q.size()), 32'd2);
    if (wr_stb_q.size() == 2) begin
      check_val("wr0_stb", 32'(wr_stb_q[0]), 32'h2);
      check_val("wr0_adr", 32'(wr_adr_q[0]), 32'h0010);
      check_val("wr0_dat", 32'(wr_dat_q[0]), 32'hA5);
      check_val("wr1_stb", 32'(wr_stb_q[1]), 32'h2);
      check_val("wr1_adr", 32'(wr_adr_q[1]), 32'h0011);
      check_val("wr1_dat", 32'(wr_dat_q[1]), 32'h3C);
    end
    reg_rd(3'd1, rd); check_val("ptr_after_wr", rd, 32'h0012);
    check_val("rom_addr_hold", 32'(rom_addr), 32'h0011);
    check_val("to_rom_hold",   32'(to_rom),   32'h3C);

    // Read from channel 0 (channel 1 carries a different value)
    reg_wr(3'd0, 32'h100);
    reg_wr(3'd1, 32'h0200);
    from_rom = {8'hC3, 8'h5A};
    bus_xfer(1'b0, 3'd2, 32'd0, rd, w);
    check_val("rd_waits", 32'(w), 32'd3);
    check_val("rd_data", rd, 32'h0000005A);
    check_val("rd_pulses", 32'(rd_stb_q.size()), 32'd1);
    if (rd_stb_q.size() == 1) begin
      check_val("rd_stb", 32'(rd_stb_q[0]), 32'h1);
      check_val("rd_adr", 32'(rd_adr_q[0]), 32'h0200);
    end
    reg_rd(3'd1, rd); check_val("ptr_after_rd", rd, 32'h0201);
    reg_rd(3'd3, rd); check_val("status_clean", rd, 32'h0);

    // HOLD clear: DATA write rejected
    reg_wr(3'd0, 32'h001);
    check_val("hold_clr", 32'(nes_hold), 32'h0);
    bus_xfer(1'b1, 3'd2, 32'h11, rd, w);
    check_val("nohold_waits", 32'(w), 32'd0);
    check_val("nohold_no_stb", 32'(wr_stb_q.size()), 32'd2);
    reg_rd(3'd3, rd); check_val("err_set", rd, 32'h2);
    reg_wr(3'd3, 32'h2);
    reg_rd(3'd3, rd); check_val("err_clr", rd, 32'h0);
    reg_rd(3'd1, rd); check_val("ptr_nohold", rd, 32'h0201);

    // Out-of-range channel read
    reg_wr(3'd0, 32'h105);
    from_rom = 16'hFFFF;
    bus_xfer(1'b0, 3'd2, 32'd0, rd, w);
    check_val("badch_waits", 32'(w), 32'd0);
    check_val("badch_data", rd, 32'h0);
    check_val("badch_no_stb", 32'(rd_stb_q.size()), 32'd1);
    reg_rd(3'd3, rd); check_val("badch_err", rd, 32'h2);
    reg_wr(3'd3, 32'h2);

    // Pointer wrap
    reg_wr(3'd0, 32'h100);
    reg_wr(3'd1, 32'hFFFF);
    bus_xfer(1'b1, 3'd2, 32'h77, rd, w);
    check_val("wrap_pulses", 32'(wr_stb_q.size()), 32'd3);
    if (wr_stb_q.size() == 3) begin
      check_val("wrap_stb", 32'(wr_stb_q[2]), 32'h1);
      check_val("wrap_adr", 32'(wr_adr_q[2]), 32'hFFFF);
    end
    reg_rd(3'd1, rd); check_val("wrap_ptr", rd, 32'h0);
    reg_rd(3'd3, rd); check_val("ovf_set", rd, 32'h4);
    reg_wr(3'd3, 32'h4);
    reg_rd(3'd3, rd); check_val("ovf_clr", rd, 32'h0);

    // Unused register indices
    reg_wr(3'd6, 32'h1234);
    reg_rd(3'd5, rd); check_val("reg5_zero", rd, 32'h0);
    reg_rd(3'd1, rd); check_val("reg6_ignored", rd, 32'h0);

`ifdef ROM_PRGMR_CHECKSUM_EN
    reg_wr(3'd4, 32'h0);
    reg_rd(3'd4, rd); check_val("csum_clr", rd, 32'h0);
    bus_xfer(1'b1, 3'd2, 32'hFF, rd, w);
    bus_xfer(1'b1, 3'd2, 32'h02, rd, w);
    reg_rd(3'd4, rd); check_val("csum_sum", rd, 32'h0101);
    reg_wr(3'd1, 32'h0);
`else
    reg_wr(3'd4, 32'hFFFF);
    reg_rd(3'd4, rd); check_val("csum_absent", rd, 32'h0);
`endif

    // Asynchronous reset during the WR cycle
    reg_wr(3'd0, 32'h101);
    @(posedge clk); #1;
    avl_cs = 1'b1; avl_addr = 3'd2; avl_write = 1'b1; avl_read = 1'b0; avl_writedata = 32'h99;
    @(posedge clk); #1;
    check_val("midwr_stb", 32'(write_rom), 32'h2);
    rst = 1'b1;
    #1;
    check_val("midwr_rst_stb",  32'(write_rom), 32'h0);
    check_val("midwr_rst_hold", 32'(nes_hold),  32'h0);
    check_val("midwr_rst_rd",   32'(read_rom),  32'h0);
    avl_cs = 1'b0; avl_write = 1'b0;
    @(negedge clk); rst = 1'b0;
    reg_rd(3'd1, rd); check_val("midwr_ptr", rd, 32'h0);
    reg_rd(3'd3, rd); check_val("midwr_status", rd, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rom_prgmr_mc.md
Name: rom_prgmr_mc

Overview:
Parametrised, multi-channel successor to the NIOS II ROM programmer. Sits on the Avalon MM bus as a slave and loads game images into up to NUM_CH ROM/RAM channels (PRG, CHR, …) through an auto-incrementing address pointer. Holds the NES core off the ROMs while loading. Inserts wait states for ROM write and read latency.

Parameters:
NUM_CH, 2, number of ROM channels (1..8)
ADDR_W, 16, ROM address width per channel
DATA_W, 8, ROM data width (<=32)
RD_LAT, 2, ROM read latency in cycles (>=1)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
AVL_ADDR  in  3  register index
AVL_CS  in  1  chip select
AVL_READ  in  1  read strobe
AVL_WRITE  in  1  write strobe
AVL_WRITEDATA  in  32  write data
AVL_READDATA  out  32  read data; valid while AVL_WAITREQUEST=0 and a read is presented
AVL_WAITREQUEST  out  1  stall
FROM_ROM  in  NUM_CH*DATA_W  per-channel read data; channel c is at [c*DATA_W +: DATA_W]
ROM_ADDR  out  ADDR_W  shared ROM address
TO_ROM  out  DATA_W  shared write data
READ_ROM  out  NUM_CH  per-channel read enable (one-hot)
WRITE_ROM  out  NUM_CH  per-channel write enable (one-hot)
NES_HOLD  out  1  high = NES core must not access the ROMs

Behaviour:
- One clock, CLK. RESET is asynchronous and active-high.
- Reset values: all outputs 0. Registers 0. FSM in IDLE.
- Register map (AVL_ADDR):
  - 0 CTRL: [2:0] CH; [8] HOLD, which drives NES_HOLD.
  - 1 PTR: [ADDR_W-1:0] pointer.
  - 2 DATA: ROM access at PTR.
  - 3 STATUS (read-only): [0] busy; [1] ERR (sticky); [2] OVF (sticky). A write of 1 to a bit clears that sticky bit.
  - 4 CSUM (see Optional Feature).
  - 5–7: reads return 0; writes are ignored.
- Non-DATA accesses complete in the same cycle with AVL_WAITREQUEST=0. AVL_READDATA is combinational from the registers, zero-extended.
- Simultaneous AVL_READ and AVL_WRITE: treated as a write.
- FSM states: IDLE, WR, RD_WAIT, DONE.
- IDLE, valid DATA write: latch data, go to WR. WAITREQUEST=1.
- WR: exactly one cycle with WRITE_ROM[CH]=1, ROM_ADDR=PTR, TO_ROM=data[DATA_W-1:0]. Then DONE.
- IDLE, valid DATA read: READ_ROM[CH]=1 and a counter is loaded. Stay in RD_WAIT for RD_LAT cycles, then capture FROM_ROM slice CH and go to DONE.
- DONE: WAITREQUEST=0 for exactly one cycle. Readdata holds the captured byte, zero-extended. PTR increments. Return to IDLE.
- Latency: DATA write = 2 wait cycles; DATA read = RD_LAT+1 wait cycles.
- A DATA access is valid only if HOLD=1 and CH<NUM_CH. Otherwise the access completes immediately: WAITREQUEST=0, readdata 0, no ROM strobe, ERR set, PTR unchanged.
- PTR wrap: incrementing from 2^ADDR_W-1 gives 0 and sets OVF.
- A PTR or CTRL write while busy cannot occur, because the master is stalled. Clearing HOLD takes effect only from IDLE.
- RESET mid-access: WRITE_ROM and READ_ROM drop immediately. No partial PTR increment. NES_HOLD=0.
- ROM_ADDR and TO_ROM hold their values when not strobing.

Optional Feature:
Macro: ROM_PRGMR_CHECKSUM_EN
- Defined: each completed DATA write adds data[DATA_W-1:0] into a 16-bit modulo-2^16 sum, readable at register 4. Any write to register 4 clears the sum to 0. Reset clears it to 0.
- Undefined: register 4 reads 0 and writes are ignored. No adder logic is present.

Decomposition:
- Package rom_prgmr_pkg:
  - register index constants REG_CTRL..REG_CSUM;
  - CTRL and STATUS bit positions;
  - FSM state enum {IDLE, WR, RD_WAIT, DONE}.
- One natural sub-module, rom_prgmr_chan_mux: decodes CH into the one-hot READ_ROM/WRITE_ROM strobes and selects the FROM_ROM slice. Pure combinational.

Test Plan:
- Write CTRL=0x101 (CH1, HOLD), PTR=0x0010, then DATA 0xA5, 0x3C -> WRITE_ROM=2'b10 for one cycle each, at ROM_ADDR 0x0010 then 0x0011, TO_ROM 0xA5 then 0x3C; PTR reads 0x0012; 2 wait cycles per write.
- CH0, PTR=0x0200, FROM_ROM[7:0]=0x5A, RD_LAT=2 -> READ_ROM=2'b01; WAITREQUEST high for 3 cycles; AVL_READDATA=0x0000005A; PTR=0x0201.
- HOLD=0, DATA write 0x11 -> no WRITE_ROM, immediate completion, STATUS=0x2; writing 0x2 to STATUS -> STATUS=0x0.
- CTRL=0x105 (CH5 with NUM_CH=2), DATA read -> readdata 0, no strobe, ERR=1.
- PTR=0xFFFF, DATA write -> strobe at 0xFFFF; PTR becomes 0x0000; OVF=1.
- RESET asserted during WR -> WRITE_ROM and NES_HOLD drop asynchronously, PTR unchanged (0). With ROM_PRGMR_CHECKSUM_EN: writes 0xFF, 0x02 -> CSUM=0x0101.
